seven_seg_demux: RTL and testbench

- Receive-side counterpart of the two-digit multiplexed 7-segment driver.
- Samples the shared segment bus and the digit-select line, waits for settling after each digit-select edge, and captures each digit.
- Reassembles the 14-bit two-digit word and decodes each digit back to a hex nibble.
- Used as a display-bus monitor/checker and as a loopback receiver in board tests.

---
 rtl/seven_seg_demux.sv | 143 ++++++++++++++
 tb/tb_seven_seg_demux.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_demux.sv
// Receiver for a two-digit multiplexed 7-segment bus: settles, captures and
// reassembles each {hi,lo} frame, decodes both glyphs and watches link health.
module seven_seg_demux #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TBITS   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic        dsel_in,
  output logic [13:0] both7seg_out,
  output logic [3:0]  hi_hex,
  output logic [3:0]  lo_hex,
  output logic        hi_ok,
  output logic        lo_ok,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        link_ok
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
  localparam logic [TBITS-1:0] TO_MAX   = TBITS'(TIMEOUT);
  localparam logic [TBITS-1:0] TO_PRE   = TBITS'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t           r_state;
  logic [6:0]       r_seg;
  logic             r_dsel;
  logic             r_dsel_prev;
  logic             r_cur_dig;
  logic [6:0]       r_seg_ref;
  logic [6:0]       r_hi_buf;
  logic             r_got_hi;
  logic [CW-1:0]    r_cnt;
  logic [TBITS-1:0] r_to_cnt;

  logic             w_edge;
  logic [13:0]      w_word;
  logic [4:0]       w_hi_dec;
  logic [4:0]       w_lo_dec;

  // Glyph to {legal, nibble}; anything outside the 16 hex glyphs is illegal.
  function automatic logic [4:0] dec7(input logic [6:0] p);
    case (p)
      7'h3F:   dec7 = 5'h10;
      7'h06:   dec7 = 5'h11;
      7'h5B:   dec7 = 5'h12;
      7'h4F:   dec7 = 5'h13;
      7'h66:   dec7 = 5'h14;
      7'h6D:   dec7 = 5'h15;
      7'h7D:   dec7 = 5'h16;
      7'h07:   dec7 = 5'h17;
      7'h7F:   dec7 = 5'h18;
      7'h6F:   dec7 = 5'h19;
      7'h77:   dec7 = 5'h1A;
      7'h7C:   dec7 = 5'h1B;
      7'h39:   dec7 = 5'h1C;
      7'h5E:   dec7 = 5'h1D;
      7'h79:   dec7 = 5'h1E;
      7'h71:   dec7 = 5'h1F;
      default: dec7 = 5'h00;
    endcase
  endfunction

  assign w_edge   = r_dsel != r_dsel_prev;
  assign w_word   = {r_hi_buf, r_seg_ref};
  assign w_hi_dec = dec7(r_hi_buf);
  assign w_lo_dec = dec7(r_seg_ref);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_seg         <= '0;
      r_dsel        <= 1'b0;
      r_dsel_prev   <= 1'b0;
      r_cur_dig     <= 1'b0;
      r_seg_ref     <= '0;
      r_hi_buf      <= '0;
      r_got_hi      <= 1'b0;
      r_cnt         <= '0;
      r_to_cnt      <= '0;
      both7seg_out  <= '0;
      hi_hex        <= '0;
      lo_hex        <= '0;
      hi_ok         <= 1'b0;
      lo_ok         <= 1'b0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      link_ok       <= 1'b0;
    end else begin
      r_seg         <= seg_in;
      r_dsel        <= dsel_in;
      r_dsel_prev   <= r_dsel;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;

      // A digit-select edge always restarts settling and beats a timeout.
      if (w_edge) begin
        r_to_cnt  <= '0;
        link_ok   <= 1'b1;
        r_cur_dig <= r_dsel;
        r_seg_ref <= r_seg;
        r_cnt     <= '0;
        r_state   <= S_SETTLE;
      end else if (r_to_cnt >= TO_PRE) begin
        r_to_cnt <= TO_MAX;
        link_ok  <= 1'b0;
        r_got_hi <= 1'b0;
        r_state  <= S_IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + TBITS'(1);
        if (r_state == S_SETTLE) begin
          if (r_seg != r_seg_ref) begin
            r_seg_ref <= r_seg;
            r_cnt     <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_HOLD;
            if (r_cur_dig) begin
              r_hi_buf <= r_seg_ref;
              r_got_hi <= 1'b1;
            end else if (r_got_hi) begin
              // Low digit closes a frame only if a high digit preceded it.
              r_got_hi      <= 1'b0;
              both7seg_out  <= w_word;
              hi_hex        <= w_hi_dec[3:0];
              hi_ok         <= w_hi_dec[4];
              lo_hex        <= w_lo_dec[3:0];
              lo_ok         <= w_lo_dec[4];
              frame_valid   <= 1'b1;
              frame_changed <= w_word != both7seg_out;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_demux.sv
// Directed bench for seven_seg_demux: expected frames are queued at stimulus
// time and checked by a monitor whenever frame_valid pulses.
module tb_seven_seg_demux;

  logic        clk;
  logic        rst;
  logic [6:0]  seg_in;
  logic        dsel_in;
  logic [13:0] both7seg_out;
  logic [3:0]  hi_hex;
  logic [3:0]  lo_hex;
  logic        hi_ok;
  logic        lo_ok;
  logic        frame_valid;
  logic        frame_changed;
  logic        link_ok;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [13:0] word;
    logic [3:0]  hh;
    logic [3:0]  lh;
    logic        hok;
    logic        lok;
    logic        chg;
  } exp_t;

  exp_t q[$];

  seven_seg_demux #(.SETTLE(4), .TIMEOUT(50), .TBITS(17)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_in),
    .dsel_in      (dsel_in),
    .both7seg_out (both7seg_out),
    .hi_hex       (hi_hex),
    .lo_hex       (lo_hex),
    .hi_ok        (hi_ok),
    .lo_ok        (lo_ok),
    .frame_valid  (frame_valid),
    .frame_changed(frame_changed),
    .link_ok      (link_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_digit(input logic d, input logic [6:0] s, input int n);
    @(negedge clk);
    dsel_in = d;
    seg_in  = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic push(input logic [13:0] w, input logic [3:0] hh, input logic [3:0] lh,
                      input logic hok, input logic lok, input logic chg);
    exp_t e;
    e.word = w; e.hh = hh; e.lh = lh; e.hok = hok; e.lok = lok; e.chg = chg;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [6:0] hi, input logic [6:0] lo);
    send_digit(1'b1, hi, 10);
    send_digit(1'b0, lo, 10);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got word 0x%0h expected no frame at %0t", both7seg_out, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("frame_word", 32'(both7seg_out), 32'(e.word));
          chk("hi_hex", 32'(hi_hex), 32'(e.hh));
          chk("lo_hex", 32'(lo_hex), 32'(e.lh));
          chk("hi_ok", 32'(hi_ok), 32'(e.hok));
          chk("lo_ok", 32'(lo_ok), 32'(e.lok));
          chk("frame_changed", 32'(frame_changed), 32'(e.chg));
        end
      end else if (frame_changed) begin
        total++;
        bad++;
        $display("FAIL changed_without_valid: got 1 expected 0 at %0t", $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    seg_in  = 7'($urandom);
    dsel_in = 1'($urandom);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", 32'({both7seg_out, hi_hex, lo_hex, hi_ok, lo_ok,
                                frame_valid, frame_changed, link_ok}), 32'd0);
      seg_in  = 7'($urandom);
      dsel_in = 1'($urandom);
    end
    rst     = 1'b0;
    seg_in  = 7'h00;
    dsel_in = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", 32'({both7seg_out, hi_hex, lo_hex, hi_ok, lo_ok,
                                   frame_valid, frame_changed, link_ok}), 32'd0);

    push(14'h1F86, 4'h0, 4'h1, 1'b1, 1'b1, 1'b1);
    send_frame(7'h3F, 7'h06);
    chk("link_up", 32'(link_ok), 32'd1);
    push(14'h1F86, 4'h0, 4'h1, 1'b1, 1'b1, 1'b0);
    send_frame(7'h3F, 7'h06);
    push(14'h1FDB, 4'h0, 4'h2, 1'b1, 1'b1, 1'b1);
    send_frame(7'h3F, 7'h5B);

    // High digit glitches through 7F for two cycles before settling on 6F
    push(14'h3786, 4'h9, 4'h1, 1'b1, 1'b1, 1'b1);
    send_digit(1'b1, 7'h7F, 2);
    send_digit(1'b1, 7'h6F, 10);
    send_digit(1'b0, 7'h06, 10);

    push(14'h38FC, 4'hF, 4'hB, 1'b1, 1'b1, 1'b1);
    send_frame(7'h71, 7'h7C);
    push(14'h3BDE, 4'hA, 4'hD, 1'b1, 1'b1, 1'b1);
    send_frame(7'h77, 7'h5E);
    push(14'h0049, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    send_frame(7'h00, 7'h49);

    // Last edge, then silence: to_cnt reaches 50 fifty cycles after it clears
    @(negedge clk);
    dsel_in = 1'b1;
    seg_in  = 7'h4F;
    repeat (51) @(posedge clk);
    #1;
    chk("link_before_timeout", 32'(link_ok), 32'd1);
    @(posedge clk);
    #1;
    chk("link_at_timeout", 32'(link_ok), 32'd0);
    chk("hold_word", 32'(both7seg_out), 32'h0049);
    chk("hold_ok", 32'({hi_ok, lo_ok}), 32'd0);

    // Low-only capture after recovery must not complete a frame
    send_digit(1'b0, 7'h06, 10);
    chk("link_recovered", 32'(link_ok), 32'd1);
    chk("hold_after_low_only", 32'(both7seg_out), 32'h0049);

    push(14'h27E6, 4'h3, 4'h4, 1'b1, 1'b1, 1'b1);
    send_frame(7'h4F, 7'h66);
    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
